// File: rtl/pathfinding_pkg.sv
// pathfinding_pkg: shared node types and explored-RAM geometry for the pathfinding blocks
package pathfinding_pkg;
  localparam int NODE_W = 272;
  localparam int ADDR_W = 7;
  localparam int MAX_NODES = 100;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } map_node;
  typedef struct packed {
    logic [31:0] node_id;
    logic [31:0] parent_id;
    logic [31:0] g_cost;
    logic [31:0] h_cost;
    map_node pos;
    logic [127:0] aux;
  } node_info;
  localparam node_info NULL_NODE = '0;
  typedef enum logic {CLEAR, RUN} ctrl_state_t;
endpackage

// File: rtl/explored_mem_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, priority starts after the last granted requester
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         ack_en,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, ptr_n;
  // scan from lowest priority to highest so the highest-priority requester wins
  always_comb begin
    gnt = '0;
    ptr_n = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (ack_en && req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        ptr_n = PW'((int'(ptr) + k + 1) % N);
      end
  end
  always_ff @(posedge clk)
    if (reset) ptr <= '0;
    else ptr <= ptr_n;
endmodule

// File: rtl/explored_mem_ctrl.sv
// explored_mem_ctrl: explored-node RAM owner: wipe, append-insert with occupancy, shared round-robin read port
module explored_mem_ctrl
  import pathfinding_pkg::*;
#(
  parameter int N_RD = 2,
  parameter int READ_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_req,
  output logic                   clear_busy,
  input  logic                   ins_req,
  input  logic [NODE_W-1:0]      ins_data,
  output logic                   ins_ack,
  output logic                   ins_ovf,
  output logic [ADDR_W-1:0]      count,
  output logic                   full,
  input  logic [N_RD-1:0]        rd_req,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_gnt,
  output logic [N_RD-1:0]        rd_valid,
  output logic [NODE_W-1:0]      rd_data,
  output logic                   mem_wren,
  output logic [ADDR_W-1:0]      mem_wraddr,
  output logic [NODE_W-1:0]      mem_data,
  output logic [ADDR_W-1:0]      mem_rdaddr,
  input  logic [NODE_W-1:0]      mem_q
);
  ctrl_state_t state, state_n;
  logic [ADDR_W-1:0] clr_addr, clr_addr_n, count_n, wraddr_n, rdaddr_n, gnt_addr;
  logic [NODE_W-1:0] data_n;
  logic wren_n, ack_n, ovf_n;
  logic [N_RD-1:0] gnt;
  logic [N_RD-1:0] vld [READ_LAT];
  assign clear_busy = state == CLEAR;
  assign rd_data = mem_q;
  assign rd_valid = vld[READ_LAT-1];
  // a client still sees its request high in the rd_gnt cycle, so mask it there
  rr_arbiter #(.N(N_RD)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(rd_req & ~rd_gnt),
    .ack_en(state == RUN),
    .gnt(gnt)
  );
  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < N_RD; i++)
      if (gnt[i]) gnt_addr = rd_addr[i*ADDR_W +: ADDR_W];
  end
  always_comb begin
    state_n = state;
    clr_addr_n = clr_addr;
    count_n = count;
    wren_n = 1'b0;
    wraddr_n = mem_wraddr;
    data_n = mem_data;
    ack_n = 1'b0;
    ovf_n = 1'b0;
    rdaddr_n = |gnt ? gnt_addr : mem_rdaddr;
    if (clear_req) begin
      state_n = CLEAR;
      clr_addr_n = '0;
    end else if (state == CLEAR) begin
      wren_n = 1'b1;
      wraddr_n = clr_addr;
      data_n = NULL_NODE;
      clr_addr_n = clr_addr + 1'b1;
      if (clr_addr == ADDR_W'(MAX_NODES - 1)) begin
        state_n = RUN;
        count_n = '0;
      end
    end else if (ins_req && full) ovf_n = 1'b1;
    else if (ins_req) begin
      wren_n = 1'b1;
      wraddr_n = count;
      data_n = ins_data;
      ack_n = 1'b1;
      count_n = count + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= CLEAR;
      clr_addr <= '0;
      count <= '0;
      full <= 1'b0;
      mem_wren <= 1'b0;
      mem_wraddr <= '0;
      mem_data <= '0;
      mem_rdaddr <= '0;
      ins_ack <= 1'b0;
      ins_ovf <= 1'b0;
      rd_gnt <= '0;
      for (int i = 0; i < READ_LAT; i++) vld[i] <= '0;
    end else begin
      state <= state_n;
      clr_addr <= clr_addr_n;
      count <= count_n;
      full <= count_n == ADDR_W'(MAX_NODES);
      mem_wren <= wren_n;
      mem_wraddr <= wraddr_n;
      mem_data <= data_n;
      mem_rdaddr <= rdaddr_n;
      ins_ack <= ack_n;
      ins_ovf <= ovf_n;
      rd_gnt <= gnt;
      vld[0] <= rd_gnt;
      for (int i = 1; i < READ_LAT; i++) vld[i] <= vld[i-1];
    end
endmodule

// File: tb/tb_explored_mem_ctrl.sv
// tb_explored_mem_ctrl: directed checks of wipe, insert/overflow, round-robin reads and reset flush
module tb_explored_mem_ctrl;
  logic clk = 0;
  logic reset, clear_req, clear_busy, ins_req, ins_ack, ins_ovf, full, mem_wren;
  logic [271:0] ins_data, rd_data, mem_data, mem_q;
  logic [6:0] count, mem_wraddr, mem_rdaddr;
  logic [1:0] rd_req, rd_gnt, rd_valid;
  logic [13:0] rd_addr;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  explored_mem_ctrl dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
    .ins_req(ins_req), .ins_data(ins_data), .ins_ack(ins_ack), .ins_ovf(ins_ovf),
    .count(count), .full(full), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .mem_wren(mem_wren), .mem_wraddr(mem_wraddr),
    .mem_data(mem_data), .mem_rdaddr(mem_rdaddr), .mem_q(mem_q)
  );
  logic [271:0] ram [128];
  logic [6:0] ra1;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_wraddr] <= mem_data;
    ra1 <= mem_rdaddr;
    mem_q <= ram[ra1];
  end
  function automatic logic [271:0] nd(int id);
    return {32'(id), 240'd0};
  endfunction
  task automatic chk(string tag, logic [271:0] obs, logic [271:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    int k, seq_bad, n;
    logic [1:0] eg [4];
    logic [6:0] ea [4];
    int ei [4];
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
    ea = '{7'd0, 7'd2, 7'd0, 7'd2};
    ei = '{5, 12, 5, 12};
    reset = 1; clear_req = 0; ins_req = 0; ins_data = '0; rd_req = '0; rd_addr = '0;
    step(); step(); step();
    chk("rst_busy", 272'(clear_busy), 272'(1));
    chk("rst_wren", 272'(mem_wren), 272'(0));
    chk("rst_count", 272'(count), 272'(0));
    chk("rst_gnt_vld", 272'({rd_gnt, rd_valid, ins_ack, ins_ovf, full}), 272'(0));
    chk("rst_addrs", 272'({mem_rdaddr, mem_wraddr}), 272'(0));
    reset = 0;
    k = 0; seq_bad = 0;
    for (int c = 0; c < 110; c++) begin
      step();
      if (mem_wren) begin
        if (mem_wraddr !== 7'(k) || mem_data !== '0) seq_bad++;
        k++;
      end
    end
    chk("wipe_writes", 272'(k), 272'(100));
    chk("wipe_seq", 272'(seq_bad), 272'(0));
    chk("wipe_done_busy", 272'(clear_busy), 272'(0));
    chk("wipe_done_count", 272'(count), 272'(0));
    ins_req = 1; ins_data = nd(5);
    step();
    chk("ins0", 272'({mem_wren, ins_ack, mem_wraddr}), 272'({2'b11, 7'd0}));
    ins_data = nd(9);
    step();
    chk("ins1", 272'({mem_wren, ins_ack, mem_wraddr}), 272'({2'b11, 7'd1}));
    ins_data = nd(12);
    step();
    chk("ins2", 272'({mem_wren, ins_ack, mem_wraddr}), 272'({2'b11, 7'd2}));
    chk("ins2_data", mem_data, nd(12));
    ins_req = 0;
    step();
    chk("ins_count", 272'({count, full}), 272'({7'd3, 1'b0}));
    chk("ins_idle", 272'({mem_wren, ins_ack}), 272'(0));
    rd_req = 2'b01; rd_addr = {7'd0, 7'd1};
    step();
    chk("rd0_gnt", 272'({rd_gnt, mem_rdaddr}), 272'({2'b01, 7'd1}));
    rd_req = 2'b00;
    step();
    chk("rd0_early", 272'(rd_valid), 272'(0));
    step();
    chk("rd0_valid", 272'(rd_valid), 272'(2'b01));
    chk("rd0_data", rd_data, nd(9));
    rd_req = 2'b10; rd_addr = {7'd2, 7'd0};
    step();
    chk("rd1_gnt", 272'({rd_gnt, mem_rdaddr}), 272'({2'b10, 7'd2}));
    rd_req = 2'b00;
    step(); step();
    chk("rd1_valid", 272'(rd_valid), 272'(2'b10));
    chk("rd1_data", rd_data, nd(12));
    rd_req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 4) chk($sformatf("rr_gnt%0d", i), 272'({rd_gnt, mem_rdaddr}), 272'({eg[i], ea[i]}));
      if (i == 3) rd_req = 2'b00;
      if (i >= 2) begin
        chk($sformatf("rr_vld%0d", i - 2), 272'(rd_valid), 272'(eg[i-2]));
        chk($sformatf("rr_data%0d", i - 2), rd_data, nd(ei[i-2]));
      end
    end
    step();
    chk("rr_quiet", 272'({rd_gnt, rd_valid}), 272'(0));
    clear_req = 1; ins_req = 1; ins_data = nd(77);
    step();
    clear_req = 0;
    chk("clr_win", 272'({ins_ack, mem_wren, clear_busy}), 272'(3'b001));
    n = 0;
    while (clear_busy && n < 150) begin
      step();
      if (clear_busy) chk("clr_no_ack", 272'(ins_ack), 272'(0));
      n++;
    end
    chk("clr_bounded", 272'(clear_busy), 272'(0));
    chk("clr_count", 272'({count, ins_ack}), 272'(0));
    step();
    chk("pend_ack", 272'({ins_ack, mem_wraddr, count}), 272'({1'b1, 7'd0, 7'd1}));
    chk("pend_data", mem_data, nd(77));
    for (int i = 0; i < 99; i++) begin
      ins_data = nd(200 + i);
      step();
    end
    chk("fill_last", 272'({ins_ack, mem_wraddr}), 272'({1'b1, 7'd99}));
    chk("fill_full", 272'({count, full}), 272'({7'd100, 1'b1}));
    step();
    chk("ovf1", 272'({ins_ovf, ins_ack, mem_wren, count}), 272'({3'b100, 7'd100}));
    step();
    chk("ovf2", 272'({ins_ovf, mem_wren, count}), 272'({2'b10, 7'd100}));
    ins_req = 0;
    step();
    chk("ovf_drop", 272'(ins_ovf), 272'(0));
    rd_req = 2'b01; rd_addr = {7'd0, 7'd1};
    step();
    chk("fl_gnt", 272'(rd_gnt), 272'(2'b01));
    rd_req = 2'b00;
    step();
    reset = 1;
    step();
    chk("fl_rst", 272'({rd_valid, clear_busy, mem_wren, count}), 272'({2'b00, 2'b10, 7'd0}));
    reset = 0;
    step();
    chk("fl_wipe0", 272'({rd_valid, mem_wren, mem_wraddr}), 272'({2'b00, 1'b1, 7'd0}));
    step();
    chk("fl_wipe1", 272'({rd_valid, mem_wren, mem_wraddr}), 272'({2'b00, 1'b1, 7'd1}));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
